bin_to_bcd_seq: RTL and testbench

//  Sequential, parametrised binary-to-BCD converter (shift-and-add-3, one bit per clock) with

---
 rtl/bin_to_bcd_seq_pkg.sv | 19 +
 rtl/bin_to_bcd_seq_add3.sv | 12 +
 rtl/bin_to_bcd_seq.sv | 145 ++++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding, BCD digit constants and the add-3 correction rule.
package bin_to_bcd_seq_pkg;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] BCD_NINE    = 4'h9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Double-dabble correction: a digit that would reach 10+ after doubling is pre-biased by 3
  function automatic logic [3:0] add3_if_ge5(input logic [3:0] digit);
    return (digit >= 4'd5) ? digit + 4'd3 : digit;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_add3.sv
// Single-digit add-3 correction cell; replicated once per BCD digit by the top.
// Purely combinational, no carry into the neighbouring digit.
module bcd_add3_digit
  import bin_to_bcd_seq_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  assign dout = add3_if_ge5(din);

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock,
// with valid/ready on both sides, overflow saturation and leading-zero mask.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int BIN_W  = 6,
  parameter int DIGITS = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BIN_W-1:0]              bin,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic                          ovf,
  output logic [DIGITS-1:0]             lz_mask
);

  localparam int ACC_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [ACC_W-1:0] SAT_BCD  = {DIGITS{BCD_NINE}};

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [BIN_W-1:0]   shreg_reg, shreg_next;
  logic [ACC_W-1:0]   acc_reg, acc_next;
  logic               sticky_reg, sticky_next;
  logic [ACC_W-1:0]   bcd_reg, bcd_next;
  logic               ovf_reg, ovf_next;
  logic [DIGITS-1:0]  lz_reg, lz_next;

  logic [ACC_W-1:0]   adj;
  logic [ACC_W-1:0]   shifted_acc;
  logic               shifted_ovf;
  logic [DIGITS-1:0]  digit_zero;
  logic [DIGITS-1:0]  lz_calc;

  genvar gi;

  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_add3_digit u_add3 (
        .din  (acc_reg[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .dout (adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
    end
  endgenerate

  // One shift step: corrected accumulator moves up, next binary MSB enters at bit 0.
  // Anything leaving the top digit means the value no longer fits in DIGITS digits.
  assign shifted_acc = {adj[ACC_W-2:0], shreg_reg[BIN_W-1]};
  assign shifted_ovf = sticky_reg | adj[ACC_W-1];

  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_zero
      assign digit_zero[gi] = (shifted_acc[gi*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
    end
    // Digit 0 is never blanked so a zero value still shows a single "0"
    assign lz_calc[0] = 1'b0;
    for (gi = 1; gi < DIGITS; gi++) begin : g_lz
      assign lz_calc[gi] = &digit_zero[DIGITS-1:gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      shreg_reg  <= '0;
      acc_reg    <= '0;
      sticky_reg <= 1'b0;
      bcd_reg    <= '0;
      ovf_reg    <= 1'b0;
      lz_reg     <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      shreg_reg  <= shreg_next;
      acc_reg    <= acc_next;
      sticky_reg <= sticky_next;
      bcd_reg    <= bcd_next;
      ovf_reg    <= ovf_next;
      lz_reg     <= lz_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    shreg_next  = shreg_reg;
    acc_next    = acc_reg;
    sticky_next = sticky_reg;
    bcd_next    = bcd_reg;
    ovf_next    = ovf_reg;
    lz_next     = lz_reg;

    case (state_reg)
      ST_IDLE: begin
        if (in_valid) begin
          shreg_next  = bin;
          acc_next    = '0;
          sticky_next = 1'b0;
          cnt_next    = CNT_LOAD;
          state_next  = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        acc_next    = shifted_acc;
        shreg_next  = shreg_reg << 1;
        sticky_next = shifted_ovf;
        cnt_next    = cnt_reg - CNT_ONE;
        // Output registers only change on the final shift so a held result never glitches
        if (cnt_reg == CNT_ONE) begin
          state_next = ST_DONE;
          ovf_next   = shifted_ovf;
          bcd_next   = shifted_ovf ? SAT_BCD : shifted_acc;
          lz_next    = shifted_ovf ? '0 : lz_calc;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign in_ready  = (state_reg == ST_IDLE);
  assign out_valid = (state_reg == ST_DONE);
  assign bcd       = bcd_reg;
  assign ovf       = ovf_reg;
  assign lz_mask   = lz_reg;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: three configurations (6b/2d, 8b/2d, 16b/5d) driven through
// a shared handshake task, checked against a decimal-arithmetic reference model.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iv = 1'b0;
  logic        ordy = 1'b1;
  logic [15:0] bin_all = '0;
  int          sel = 0;
  int          cyc = 0;

  int n_vec = 0;
  int n_fail = 0;
  int acc_cyc = 0;

  logic        in_ready6, out_valid6, ovf6;
  logic [7:0]  bcd6;
  logic [1:0]  lz6;
  logic        in_ready8, out_valid8, ovf8;
  logic [7:0]  bcd8;
  logic [1:0]  lz8;
  logic        in_ready16, out_valid16, ovf16;
  logic [19:0] bcd16;
  logic [4:0]  lz16;

  logic        rdy_m, ov_m, ovf_m;
  logic [19:0] bcd_m;
  logic [4:0]  lz_m;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bin_to_bcd_seq #(.BIN_W(6), .DIGITS(2)) u_dut6 (
    .clk(clk), .rst(rst), .in_valid(iv && sel == 0), .in_ready(in_ready6),
    .bin(bin_all[5:0]), .out_valid(out_valid6), .out_ready(ordy),
    .bcd(bcd6), .ovf(ovf6), .lz_mask(lz6));

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv && sel == 1), .in_ready(in_ready8),
    .bin(bin_all[7:0]), .out_valid(out_valid8), .out_ready(ordy),
    .bcd(bcd8), .ovf(ovf8), .lz_mask(lz8));

  bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(iv && sel == 2), .in_ready(in_ready16),
    .bin(bin_all), .out_valid(out_valid16), .out_ready(ordy),
    .bcd(bcd16), .ovf(ovf16), .lz_mask(lz16));

  always_comb begin
    rdy_m = 1'b0; ov_m = 1'b0; ovf_m = 1'b0; bcd_m = '0; lz_m = '0;
    case (sel)
      0: begin rdy_m = in_ready6;  ov_m = out_valid6;  ovf_m = ovf6;  bcd_m = {12'd0, bcd6}; lz_m = {3'd0, lz6}; end
      1: begin rdy_m = in_ready8;  ov_m = out_valid8;  ovf_m = ovf8;  bcd_m = {12'd0, bcd8}; lz_m = {3'd0, lz8}; end
      default: begin rdy_m = in_ready16; ov_m = out_valid16; ovf_m = ovf16; bcd_m = bcd16; lz_m = lz16; end
    endcase
  end

  function automatic int bw_of(input int s);
    return (s == 0) ? 6 : (s == 1) ? 8 : 16;
  endfunction

  function automatic int dig_of(input int s);
    return (s == 2) ? 5 : 2;
  endfunction

  // Reference: plain decimal arithmetic on the integer value
  function automatic void model(input int unsigned v, input int d,
                                output logic [19:0] b, output logic o, output logic [4:0] lz);
    int unsigned p;
    b = '0; lz = '0; p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    o = (v >= p);
    if (o) begin
      for (int i = 0; i < d; i++) b[4*i +: 4] = 4'h9;
    end else begin
      p = 1;
      for (int i = 0; i < d; i++) begin
        b[4*i +: 4] = 4'((v / p) % 10);
        if (i > 0) lz[i] = (v < p);
        p = p * 10;
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic convert(input int s, input int unsigned v, output logic [19:0] b,
                         output logic o, output logic [4:0] lz, output int lat);
    int n;
    sel = s;
    @(negedge clk);
    bin_all = v[15:0];
    iv = 1'b1;
    n = 0;
    while (!rdy_m && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rdy_m) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    iv = 1'b0;
    acc_cyc = cyc;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
    end while (!ov_m && lat < 100);
    b = bcd_m;
    o = ovf_m;
    lz = lz_m;
  endtask

  typedef struct {
    int          s;
    int unsigned v;
    logic [19:0] b;
    logic        o;
    logic [4:0]  lz;
  } vec_t;

  vec_t tbl[14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [19:0] b, eb, held;
    logic        o, eo;
    logic [4:0]  lz, elz;
    int          lat, prev_cyc, n, s;
    int unsigned v;

    tbl = '{
      '{0, 7,     20'h00007, 1'b0, 5'b00010},
      '{0, 0,     20'h00000, 1'b0, 5'b00010},
      '{0, 10,    20'h00010, 1'b0, 5'b00000},
      '{0, 59,    20'h00059, 1'b0, 5'b00000},
      '{0, 63,    20'h00063, 1'b0, 5'b00000},
      '{1, 200,   20'h00099, 1'b1, 5'b00000},
      '{1, 99,    20'h00099, 1'b0, 5'b00000},
      '{1, 100,   20'h00099, 1'b1, 5'b00000},
      '{1, 255,   20'h00099, 1'b1, 5'b00000},
      '{1, 5,     20'h00005, 1'b0, 5'b00010},
      '{2, 65535, 20'h65535, 1'b0, 5'b00000},
      '{2, 0,     20'h00000, 1'b0, 5'b11110},
      '{2, 1000,  20'h01000, 1'b0, 5'b10000},
      '{2, 40960, 20'h40960, 1'b0, 5'b00000}
    };

    // Reset state of every configuration
    repeat (3) @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      sel = k;
      #1;
      chk("rst_in_ready", 32'(rdy_m), 32'd1);
      chk("rst_out_valid", 32'(ov_m), 32'd0);
      chk("rst_bcd", 32'(bcd_m), 32'd0);
      chk("rst_ovf_lz", {26'd0, ovf_m, lz_m}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 14; i++) begin
      convert(tbl[i].s, tbl[i].v, b, o, lz, lat);
      $display("vec %0d: cfg=%0d bin=%0d bcd=%0h ovf=%0b lz=%b lat=%0d",
               i, tbl[i].s, tbl[i].v, b, o, lz, lat);
      chk("tbl_bcd", 32'(b), 32'(tbl[i].b));
      chk("tbl_ovf", 32'(o), 32'(tbl[i].o));
      chk("tbl_lz", 32'(lz), 32'(tbl[i].lz));
      chk("tbl_latency", 32'(lat), 32'(bw_of(tbl[i].s)));
    end

    // Full 6-bit sweep with throughput check
    prev_cyc = 0;
    for (int unsigned x = 0; x < 64; x++) begin
      convert(0, x, b, o, lz, lat);
      model(x, 2, eb, eo, elz);
      $display("sweep bin=%0d bcd=%0h ovf=%0b lz=%b lat=%0d", x, b, o, lz, lat);
      chk("sweep_bcd", 32'(b), 32'(eb));
      chk("sweep_ovf", 32'(o), 32'(eo));
      chk("sweep_lz", 32'(lz), 32'(elz));
      chk("sweep_latency", 32'(lat), 32'd6);
      if (x > 0) chk("sweep_throughput", 32'(acc_cyc - prev_cyc), 32'd8);
      prev_cyc = acc_cyc;
    end

    // Random values on random configurations
    for (int i = 0; i < 40; i++) begin
      s = $urandom_range(0, 2);
      v = $urandom & ((32'd1 << bw_of(s)) - 1);
      convert(s, v, b, o, lz, lat);
      model(v, dig_of(s), eb, eo, elz);
      $display("rand cfg=%0d bin=%0d bcd=%0h ovf=%0b lz=%b lat=%0d", s, v, b, o, lz, lat);
      chk("rand_bcd", 32'(b), 32'(eb));
      chk("rand_ovf", 32'(o), 32'(eo));
      chk("rand_lz", 32'(lz), 32'(elz));
      chk("rand_latency", 32'(lat), 32'(bw_of(s)));
    end

    // Backpressure: result held, busy inputs ignored
    ordy = 1'b0;
    convert(0, 37, b, o, lz, lat);
    held = b;
    chk("bp_bcd", 32'(b), 32'h37);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      iv = 1'b1;
      bin_all = 16'(k + 3);
      chk("bp_out_valid", 32'(ov_m), 32'd1);
      chk("bp_in_ready", 32'(rdy_m), 32'd0);
      chk("bp_bcd_stable", 32'(bcd_m), 32'(held));
    end
    @(negedge clk);
    iv = 1'b0;
    ordy = 1'b1;
    @(posedge clk);
    #1;
    $display("bp release: in_ready=%0b out_valid=%0b", rdy_m, ov_m);
    chk("bp_release_in_ready", 32'(rdy_m), 32'd1);
    chk("bp_release_out_valid", 32'(ov_m), 32'd0);
    convert(0, 21, b, o, lz, lat);
    $display("post-bp bin=21 bcd=%0h", b);
    chk("bp_next_bcd", 32'(b), 32'h21);

    // Reset three clocks into SHIFT
    @(negedge clk);
    n = 0;
    while (!rdy_m && n < 50) begin
      @(negedge clk);
      n++;
    end
    bin_all = 16'd63;
    iv = 1'b1;
    @(posedge clk);
    #1;
    iv = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    $display("mid-shift reset: in_ready=%0b out_valid=%0b bcd=%0h", rdy_m, ov_m, bcd_m);
    chk("mrst_out_valid", 32'(ov_m), 32'd0);
    chk("mrst_in_ready", 32'(rdy_m), 32'd1);
    chk("mrst_bcd", 32'(bcd_m), 32'd0);
    chk("mrst_ovf_lz", {26'd0, ovf_m, lz_m}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    convert(0, 42, b, o, lz, lat);
    $display("post-reset bin=42 bcd=%0h ovf=%0b lz=%b lat=%0d", b, o, lz, lat);
    chk("mrst_bcd42", 32'(b), 32'h42);
    chk("mrst_ovf42", 32'(o), 32'd0);
    chk("mrst_lz42", 32'(lz), 32'd0);
    chk("mrst_lat42", 32'(lat), 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
